// File: rtl/memory_sequencer_if.sv
// memory_sequencer_if
//   Bundles the CPU-side access handshake and the byte-wide memory_bus side of
//   memory_sequencer into one interface.
//   slave  : view used by memory_sequencer itself.
//   master : complementary view for whatever drives the sequencer (core/bus).
//   CPU side : start, write, size, address, wdata -> rdata, busy, done, error
//   Bus side : bus_address, bus_data_out, bus_enable, bus_write_enable ->
//              bus_data_in, bus_halt
interface memory_sequencer_if;
  logic        start;
  logic        write;
  logic [1:0]  size;
  logic [23:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [23:0] bus_address;
  logic [7:0]  bus_data_out;
  logic [7:0]  bus_data_in;
  logic        bus_enable;
  logic        bus_write_enable;
  logic        bus_halt;

  modport slave (
    input  start, write, size, address, wdata, bus_data_in, bus_halt,
    output rdata, busy, done, error, bus_address, bus_data_out, bus_enable,
           bus_write_enable
  );

  modport master (
    output start, write, size, address, wdata, bus_data_in, bus_halt,
    input  rdata, busy, done, error, bus_address, bus_data_out, bus_enable,
           bus_write_enable
  );
endinterface

// File: rtl/memory_sequencer.sv
// memory_sequencer
//   Splits one CPU data access of 1-4 bytes into single-byte memory_bus
//   transactions, little-endian at consecutive (24-bit wrapping) addresses.
//   Each byte waits out bus_halt. Completion is a one-cycle done pulse; read
//   data is assembled in rdata and held until the next read is accepted.
// Ports
//   clk   : system clock (shared with memory_bus)
//   reset : synchronous, active-low
//   sq    : memory_sequencer_if.slave (CPU handshake + byte bus)
// Parameters
//   TIMEOUT_CYCLES : halted HOLD cycles per byte before abort (>= 1)
// Build option
//   MEMORY_SEQUENCER_TIMEOUT_EN : when defined, a stuck bus_halt aborts the
//   access after TIMEOUT_CYCLES halted cycles and flags error with done.
//   When undefined, HOLD waits indefinitely and error is tied low.
//
// state | meaning
// IDLE  | waiting for start; access parameters latched on start
// ISSUE | one-cycle byte issue; write strobe asserted here only
// HOLD  | byte in flight; wait for bus_halt low, capture read byte
// DONE  | one-cycle done pulse, bus released
module memory_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input logic               clk,
  input logic               reset,
  memory_sequencer_if.slave sq
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        write_q;
  logic [1:0]  size_q;
  logic [23:0] address_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [1:0]  index;

  logic        accept;
  logic        byte_ok;
  logic        last_byte;
  logic        abort;
  logic [23:0] cur_address;
  logic [7:0]  cur_wbyte;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("memory_sequencer: TIMEOUT_CYCLES must be at least 1");
  end

  assign accept      = (state == IDLE) && sq.start;
  assign byte_ok     = (state == HOLD) && !sq.bus_halt;
  assign last_byte   = (index == size_q);
  assign cur_address = address_q + {22'd0, index};
  assign cur_wbyte   = wdata_q[{index, 3'b000} +: 8];

`ifdef MEMORY_SEQUENCER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] halt_cnt;
  logic          error_q;

  // Abort on the halted cycle that would bring the count to TIMEOUT_CYCLES.
  assign abort = (state == HOLD) && sq.bus_halt &&
                 (halt_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      halt_cnt <= '0;
      error_q  <= 1'b0;
    end else begin
      if (state == ISSUE)
        halt_cnt <= '0;
      else if ((state == HOLD) && sq.bus_halt)
        halt_cnt <= halt_cnt + CW'(1);
      if (accept)
        error_q <= 1'b0;
      else if (abort)
        error_q <= 1'b1;
    end
  end

  assign sq.error = (state == DONE) && error_q;
`else
  assign abort    = 1'b0;
  assign sq.error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt           = state;
    sq.busy             = 1'b1;
    sq.done             = 1'b0;
    sq.bus_enable       = 1'b0;
    sq.bus_write_enable = 1'b0;
    sq.bus_address      = '0;
    sq.bus_data_out     = '0;
    case (state)
      IDLE: begin
        sq.busy = 1'b0;
        if (sq.start) state_nxt = ISSUE;
      end
      ISSUE: begin
        sq.bus_enable       = 1'b1;
        sq.bus_write_enable = write_q;
        sq.bus_address      = cur_address;
        sq.bus_data_out     = cur_wbyte;
        state_nxt           = HOLD;
      end
      HOLD: begin
        sq.bus_enable   = 1'b1;
        sq.bus_address  = cur_address;
        sq.bus_data_out = cur_wbyte;
        if (!sq.bus_halt)
          state_nxt = last_byte ? DONE : ISSUE;
        else if (abort)
          state_nxt = DONE;
      end
      DONE: begin
        sq.done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Access parameters and read assembly. A write leaves rdata untouched so
  // the last read value stays visible to the core.
  always_ff @(posedge clk) begin
    if (!reset) begin
      write_q   <= 1'b0;
      size_q    <= 2'd0;
      address_q <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      index     <= 2'd0;
    end else if (accept) begin
      write_q   <= sq.write;
      size_q    <= sq.size;
      address_q <= sq.address;
      wdata_q   <= sq.wdata;
      index     <= 2'd0;
      if (!sq.write) rdata_q <= '0;
    end else if (byte_ok) begin
      if (!write_q) rdata_q[{index, 3'b000} +: 8] <= sq.bus_data_in;
      if (!last_byte) index <= index + 2'd1;
    end
  end

  assign sq.rdata = rdata_q;

endmodule

// File: tb/tb_memory_sequencer.sv
module tb_memory_sequencer;

  logic clk;
  logic reset;

  memory_sequencer_if sq();

  memory_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .sq    (sq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- bus-side memory model ----------------
  logic [7:0] mem[int];      // contents as written by the DUT over the bus
  logic [7:0] ref_mem[int];  // contents the access rules say memory should hold
  int         plan[4];       // halted cycles to insert for each byte
  int         bidx;
  int         hold_left;
  bit         in_byte;
  logic [23:0] iss_addr[$];
  logic [7:0]  iss_data[$];
  logic        iss_we[$];
  int         done_cnt = 0;
  int         hold_we_err = 0;

  function automatic logic [7:0] dflt(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] bus_rd(input logic [23:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : dflt(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [23:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
  endfunction

  // Byte bus responder: first enabled cycle of a byte is the issue, further
  // enabled cycles are the hold; halt is raised for the planned count.
  always @(negedge clk) begin
    if (!reset || !sq.bus_enable) begin
      in_byte        = 1'b0;
      sq.bus_halt    = 1'b0;
      sq.bus_data_in = 8'h00;
    end else if (!in_byte) begin
      iss_addr.push_back(sq.bus_address);
      iss_data.push_back(sq.bus_data_out);
      iss_we.push_back(sq.bus_write_enable);
      if (sq.bus_write_enable) mem[int'(sq.bus_address)] = sq.bus_data_out;
      hold_left      = (bidx < 4) ? plan[bidx] : 0;
      bidx++;
      in_byte        = 1'b1;
      sq.bus_halt    = 1'b0;
      sq.bus_data_in = 8'($urandom);
    end else begin
      if (sq.bus_write_enable) hold_we_err++;
      if (hold_left > 0) begin
        sq.bus_halt    = 1'b1;
        sq.bus_data_in = 8'($urandom);
        hold_left--;
      end else begin
        sq.bus_halt    = 1'b0;
        sq.bus_data_in = bus_rd(sq.bus_address);
        in_byte        = 1'b0;
      end
    end
    if (sq.done === 1'b1) done_cnt++;
  end

  // ---------------- one complete access ----------------
  task automatic do_access(input string nm, input logic wr, input logic [1:0] sz,
                           input logic [23:0] a, input logic [31:0] wd, input bit spur,
                           input int exp_lat, input logic [31:0] exp_rd);
    int n, cnt, d0, hwe0;
    logic [23:0] ea;
    n    = int'(sz) + 1;
    d0   = done_cnt;
    hwe0 = hold_we_err;
    iss_addr.delete(); iss_data.delete(); iss_we.delete();
    bidx = 0;
    sq.start = 1'b1; sq.write = wr; sq.size = sz; sq.address = a; sq.wdata = wd;
    @(negedge clk); #2;
    sq.write = 1'($urandom); sq.size = 2'($urandom);
    sq.address = 24'($urandom); sq.wdata = $urandom;
    cnt = 1;
    while (sq.done !== 1'b1 && cnt < 300) begin
      sq.start = spur && (cnt == 2);
      @(negedge clk); #2;
      cnt++;
    end
    sq.start = 1'b0;
    chk({nm, " latency"}, 64'(cnt), 64'(exp_lat));
    chk({nm, " error"}, 64'(sq.error), 64'd0);
    chk({nm, " busy@done"}, 64'(sq.busy), 64'd1);
    chk({nm, " rdata"}, 64'(sq.rdata), 64'(exp_rd));
    chk({nm, " bytes issued"}, 64'(iss_addr.size()), 64'(n));
    for (int k = 0; k < n; k++) begin
      if (k < iss_addr.size()) begin
        ea = a + 24'(k);
        chk($sformatf("%s addr%0d", nm, k), 64'(iss_addr[k]), 64'(ea));
        chk($sformatf("%s we%0d", nm, k), 64'(iss_we[k]), 64'(wr));
        if (wr) chk($sformatf("%s wbyte%0d", nm, k), 64'(iss_data[k]), 64'(wd[8*k +: 8]));
      end
    end
    @(negedge clk); #2;
    chk({nm, " done after"}, 64'(sq.done), 64'd0);
    chk({nm, " busy after"}, 64'(sq.busy), 64'd0);
    chk({nm, " rdata held"}, 64'(sq.rdata), 64'(exp_rd));
    chk({nm, " done pulses"}, 64'(done_cnt - d0), 64'd1);
    chk({nm, " we in hold"}, 64'(hold_we_err - hwe0), 64'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic [23:0] addr;
    logic [31:0] wd;
    logic [15:0] halts;   // nibble k = halted cycles on byte k
    bit          spur;
    int          lat;
    logic [31:0] rd;
  } vec_t;

  localparam int NV = 7;
  vec_t vt[NV];
  logic [31:0] last_rd;

  task automatic set_plan(input logic [15:0] h);
    for (int k = 0; k < 4; k++) plan[k] = int'(h[4*k +: 4]);
  endtask

  task automatic preload(input logic [23:0] a, input logic [7:0] d);
    mem[int'(a)] = d;
    ref_mem[int'(a)] = d;
  endtask

  initial begin
    int cnt, busy_low, lat;
    logic wr;
    logic [1:0] sz;
    logic [23:0] a;
    logic [31:0] wd, erd;
    logic [15:0] h;
    bit spur;

    vt[0] = '{1'b0, 2'd0, 24'h001234, 32'h0,        16'h0000, 1'b0, 3,  32'h000000A5};
    vt[1] = '{1'b1, 2'd3, 24'h00FFFE, 32'hDEADBEEF, 16'h0000, 1'b1, 9,  32'h000000A5};
    vt[2] = '{1'b0, 2'd1, 24'hFFFFFF, 32'h0,        16'h0005, 1'b0, 10, 32'h0000C33C};
    vt[3] = '{1'b0, 2'd3, 24'h00FFFE, 32'h0,        16'h2010, 1'b0, 12, 32'hDEADBEEF};
    vt[4] = '{1'b0, 2'd2, 24'h000010, 32'h0,        16'h0000, 1'b1, 7,  32'h00332211};
    vt[5] = '{1'b1, 2'd0, 24'h000011, 32'h12345677, 16'h0000, 1'b0, 3,  32'h00332211};
    vt[6] = '{1'b0, 2'd1, 24'h000010, 32'h0,        16'h0022, 1'b0, 9,  32'h00007711};

    preload(24'h001234, 8'hA5);
    preload(24'hFFFFFF, 8'h3C);
    preload(24'h000000, 8'hC3);
    preload(24'h000010, 8'h11);
    preload(24'h000011, 8'h22);
    preload(24'h000012, 8'h33);

    reset = 1'b0;
    sq.start = 1'b0; sq.write = 1'b0; sq.size = 2'd0; sq.address = '0; sq.wdata = '0;
    for (int k = 0; k < 4; k++) plan[k] = 0;
    bidx = 0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset rdata", 64'(sq.rdata), 64'd0);
    chk("reset busy", 64'(sq.busy), 64'd0);
    chk("reset done", 64'(sq.done), 64'd0);
    chk("reset error", 64'(sq.error), 64'd0);
    chk("reset bus_address", 64'(sq.bus_address), 64'd0);
    chk("reset bus_data_out", 64'(sq.bus_data_out), 64'd0);
    chk("reset bus_enable", 64'(sq.bus_enable), 64'd0);
    chk("reset bus_write_enable", 64'(sq.bus_write_enable), 64'd0);
    reset = 1'b1;
    @(negedge clk); #2;

    // Directed vectors, back-to-back.
    last_rd = 32'h0;
    for (int i = 0; i < NV; i++) begin
      set_plan(vt[i].halts);
      do_access($sformatf("vec%0d", i), vt[i].wr, vt[i].sz, vt[i].addr, vt[i].wd,
                vt[i].spur, vt[i].lat, vt[i].rd);
      if (vt[i].wr)
        for (int k = 0; k <= int'(vt[i].sz); k++) ref_mem[int'(vt[i].addr + 24'(k))] = vt[i].wd[8*k +: 8];
      else
        last_rd = vt[i].rd;
    end

    // Reset in HOLD of byte 2 of a 32-bit read.
    set_plan(16'h0F00);
    plan[2] = 1000;
    bidx = 0;
    sq.start = 1'b1; sq.write = 1'b0; sq.size = 2'd3; sq.address = 24'h000100;
    @(negedge clk); #2;
    sq.start = 1'b0;
    for (int c = 1; c < 6; c++) begin @(negedge clk); #2; end
    chk("midreset in hold", 64'(sq.bus_enable), 64'd1);
    chk("midreset hold addr", 64'(sq.bus_address), 64'h000102);
    reset = 1'b0;
    @(negedge clk); #2;
    chk("midreset rdata", 64'(sq.rdata), 64'd0);
    chk("midreset busy", 64'(sq.busy), 64'd0);
    chk("midreset done", 64'(sq.done), 64'd0);
    chk("midreset error", 64'(sq.error), 64'd0);
    chk("midreset bus_address", 64'(sq.bus_address), 64'd0);
    chk("midreset bus_data_out", 64'(sq.bus_data_out), 64'd0);
    chk("midreset bus_enable", 64'(sq.bus_enable), 64'd0);
    chk("midreset bus_write_enable", 64'(sq.bus_write_enable), 64'd0);
    reset = 1'b1;
    @(negedge clk); #2;
    set_plan(16'h0000);
    erd = {24'h0, ref_rd(24'h000100)};
    do_access("after reset", 1'b0, 2'd0, 24'h000100, 32'h0, 1'b0, 3, erd);
    last_rd = erd;

    // Halt stuck high on byte 1 of a 16-bit read.
    set_plan(16'h0000);
    plan[1] = 1000;
    bidx = 0;
    sq.start = 1'b1; sq.write = 1'b0; sq.size = 2'd1; sq.address = 24'h000200;
    @(negedge clk); #2;
    sq.start = 1'b0;
`ifdef MEMORY_SEQUENCER_TIMEOUT_EN
    cnt = 1;
    while (sq.done !== 1'b1 && cnt < 100) begin @(negedge clk); #2; cnt++; end
    chk("timeout latency", 64'(cnt), 64'd12);
    chk("timeout error", 64'(sq.error), 64'd1);
    erd = {24'h0, ref_rd(24'h000200)};
    chk("timeout partial rdata", 64'(sq.rdata), 64'(erd));
    @(negedge clk); #2;
    chk("timeout idle", 64'(sq.busy), 64'd0);
    chk("timeout error clears", 64'(sq.error), 64'd0);
    last_rd = erd;
`else
    busy_low = 0;
    repeat (60) begin
      @(negedge clk); #2;
      if (sq.busy !== 1'b1 || sq.done !== 1'b0) busy_low++;
    end
    chk("stuck halt waits", 64'(busy_low), 64'd0);
    chk("stuck halt error", 64'(sq.error), 64'd0);
    reset = 1'b0;
    @(negedge clk); #2;
    reset = 1'b1;
    @(negedge clk); #2;
    chk("stuck halt recovered", 64'(sq.busy), 64'd0);
    last_rd = 32'h0;
`endif

    // Randomized accesses against the access rules.
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom);
      sz = 2'($urandom);
      a  = (i % 4 == 0) ? (24'hFFFFFF - 24'($urandom_range(0, 3))) : 24'($urandom);
      wd = $urandom;
      h  = 16'($urandom) & 16'h3333;
      spur = 1'($urandom);
      set_plan(h);
      lat = 2 * (int'(sz) + 1) + 1;
      erd = 32'h0;
      for (int k = 0; k <= int'(sz); k++) begin
        lat += plan[k];
        erd[8*k +: 8] = ref_rd(a + 24'(k));
      end
      if (wr) erd = last_rd;
      do_access($sformatf("rnd%0d", i), wr, sz, a, wd, spur, lat, erd);
      if (wr)
        for (int k = 0; k <= int'(sz); k++) ref_mem[int'(a + 24'(k))] = wd[8*k +: 8];
      else
        last_rd = erd;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memory_sequencer.md
# memory_sequencer

Sits between the W65C832 core and `memory_bus` and turns one CPU data access of 1–4 bytes into a sequence of single-byte bus transactions. Bytes are issued little-endian at consecutive addresses, and each byte waits out `bus_halt` while the SPI flash is busy. The assembled read word or the write completion is returned to the core with a one-cycle `done` pulse. This keeps all multi-byte and halt handling out of the core's instruction state machine.

## Interface
- `TIMEOUT_CYCLES`, default 1023: halt cycles per byte before abort. Used only when `MEMORY_SEQUENCER_TIMEOUT_EN` is defined.
- `clk` in 1: system clock, the same `clk` given to `memory_bus`.
- `reset` in 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start` in 1: access request, sampled only in IDLE.
- `write` in 1: 1 = write, 0 = read; latched at start.
- `size` in 2: byte count minus 1 (0 = 8-bit, 1 = 16-bit, 2 = 24-bit, 3 = 32-bit); latched at start.
- `address` in 24: address of the first byte; latched at start.
- `wdata` in 32: write data, byte 0 = [7:0]; latched at start.
- `rdata` out 32: assembled read data.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: timeout abort flag, valid while `done` is high.
- `bus_address` out 24: to `memory_bus` `address`.
- `bus_data_out` out 8: to `memory_bus` `data_in`.
- `bus_data_in` in 8: from `memory_bus` `data_out`.
- `bus_enable` out 1: byte transaction active.
- `bus_write_enable` out 1: byte write strobe.
- `bus_halt` in 1: from `memory_bus`; high means the current byte is not ready.

## Operation
- **States:** IDLE, ISSUE, HOLD, DONE.
- **IDLE:**
  - On `start`=1, latch `write`, `size`, `address` and `wdata`.
  - Clear the byte index to 0, clear `rdata` (unless `write`), and go to ISSUE.
- **ISSUE:**
  - `bus_address` = latched address + index (24-bit add, wraps 0xFFFFFF→0x000000).
  - `bus_enable` = 1.
  - `bus_data_out` = `wdata` byte[index].
  - `bus_write_enable` = `write`, asserted in the ISSUE cycle only.
  - Go to HOLD.
- **HOLD:**
  - `bus_address` and `bus_enable` are held; `bus_write_enable` = 0.
  - If `bus_halt`=1, stay in HOLD.
  - If `bus_halt`=0 on a read, capture `bus_data_in` into `rdata` byte[index].
  - If `bus_halt`=0 and index == `size`, go to DONE.
  - If `bus_halt`=0 and index < `size`, increment index and go to ISSUE.
- **DONE:** `done` = 1 for this single cycle, then go to IDLE. A new `start` is accepted on the following cycle.
- **`rdata` contents:**
  - Unread upper bytes read as 0.
  - `rdata` holds its value until the next read is accepted; writes do not modify it.
- **`start` while not IDLE:** ignored, never queued.
- **Reset:** active at any state, including mid-sequence. It forces IDLE and clears all outputs to 0: `rdata`, `busy`, `done`, `error`, all bus outputs, and the index. A partially written multi-byte value is not rolled back.

## Timing
- Reset values: every output is 0.
- With `start` sampled at edge N and no halt, `done` is high in cycle N+2n+1 for an access of n bytes:
  - 8-bit: 3 cycles.
  - 16-bit: 5 cycles.
  - 24-bit: 7 cycles.
  - 32-bit: 9 cycles.
- Each halted cycle in HOLD adds exactly 1 cycle.
- `rdata` is valid in the `done` cycle and afterwards.
- `bus_enable` drops for no cycle within a byte. It is low for exactly the DONE cycle and all IDLE cycles.
- Back-to-back accesses: the next `start` can be sampled in the IDLE cycle immediately after DONE.

## Configuration
- Macro: `MEMORY_SEQUENCER_TIMEOUT_EN`.
- **Defined:**
  - A counter clears on entry to HOLD and increments on each HOLD cycle with `bus_halt`=1.
  - When it reaches `TIMEOUT_CYCLES`, the access is aborted: go to DONE with `error`=1 and skip the remaining bytes.
  - `rdata` keeps the bytes captured so far.
- **Not defined:** HOLD waits indefinitely, `error` is tied to 0, and no counter is built.

## Test plan
- 8-bit read at 0x001234 with `bus_data_in`=0xA5 and no halt: `done` in the third cycle after `start`, `rdata`=0x000000A5, one ISSUE on `bus_address`=0x001234.
- 32-bit write of 0xDEADBEEF at 0x00FFFE: four `bus_write_enable` pulses.
  - Addresses in order: 0x00FFFE, 0x00FFFF, 0x010000, 0x010001.
  - Data in order: EF, BE, AD, DE.
  - `done` at cycle 9.
- 16-bit read at 0xFFFFFF with `bus_halt` high for 5 cycles on byte 0: addresses 0xFFFFFF then 0x000000, `done` at cycle 10, `rdata`={byte1, byte0}.
- Reset low in HOLD of byte 2 of a 32-bit read:
  - Next cycle: IDLE, all outputs 0.
  - A subsequent 8-bit read completes normally.
- `start` pulsed while `busy`: ignored, exactly one `done` is produced.
- With the macro and `TIMEOUT_CYCLES`=8, `bus_halt` stuck high: `done`=1 and `error`=1 after 8 halt cycles, then IDLE. Without the macro, `busy` stays high indefinitely.
